// File: rtl/feedback_suppressor_ctrl.sv
// feedback_suppressor_ctrl: howl detector that sequences a suppression gain through attack, hold and release.
// Ports: i_clk, i_reset (sync, active-high), i_enable (low forces bypass), i_valid/i_data (signed 8-bit samples),
//   o_gain (registered Q0.8 gain, FF = unity), o_active (state != MONITOR), o_state (0 MONITOR,1 ATTACK,2 HOLD,3 RELEASE).
// Optional: define FBS_CTRL_EVENT_COUNT_EN to add o_event_count, a saturating count of MONITOR->ATTACK triggers.
module feedback_suppressor_ctrl #(
  parameter logic [7:0] THRESHOLD    = 8'd100,
  parameter int         DETECT_COUNT = 16,
  parameter int         HOLD_SAMPLES = 32,
  parameter logic [7:0] GAIN_MIN     = 8'h40,
  parameter logic [7:0] GAIN_STEP    = 8'h10
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic [7:0] o_gain,
`ifdef FBS_CTRL_EVENT_COUNT_EN
  output logic [7:0] o_event_count,
`endif
  output logic       o_active,
  output logic [1:0] o_state
);
  typedef enum logic [1:0] {MONITOR, ATTACK, HOLD, RELEASE} state_t;
  localparam logic [7:0]  DET_N  = 8'(DETECT_COUNT);
  localparam logic [15:0] HOLD_N = 16'(HOLD_SAMPLES);
  state_t      state;
  logic [7:0]  loud_cnt;
  logic [15:0] hold_cnt;
  logic [7:0]  mag, loud_nxt, gain_dn_sat, gain_up_sat;
  logic        loud;
  logic [8:0]  gain_dn, gain_up;
  // -128 has no positive counterpart in 8 bits, so it saturates to 127
  assign mag         = (i_data == 8'h80) ? 8'd127 : (i_data[7] ? 8'(-i_data) : i_data);
  assign loud        = mag >= THRESHOLD;
  assign loud_nxt    = !loud ? 8'd0 : (loud_cnt >= DET_N ? DET_N : loud_cnt + 8'd1);
  // borrow/carry in bit 8 flags wrap before the clamp is applied
  assign gain_dn     = {1'b0, o_gain} - {1'b0, GAIN_STEP};
  assign gain_up     = {1'b0, o_gain} + {1'b0, GAIN_STEP};
  assign gain_dn_sat = (gain_dn[8] || gain_dn[7:0] < GAIN_MIN) ? GAIN_MIN : gain_dn[7:0];
  assign gain_up_sat = gain_up[8] ? 8'hFF : gain_up[7:0];
  assign o_state     = state;
  assign o_active    = state != MONITOR;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= MONITOR;
      o_gain   <= 8'hFF;
      loud_cnt <= '0;
      hold_cnt <= '0;
`ifdef FBS_CTRL_EVENT_COUNT_EN
      o_event_count <= '0;
`endif
    end else if (!i_enable) begin
      state    <= MONITOR;
      o_gain   <= 8'hFF;
      loud_cnt <= '0;
      hold_cnt <= '0;
    end else if (i_valid) begin
      case (state)
        MONITOR: begin
          o_gain   <= 8'hFF;
          loud_cnt <= loud_nxt;
          if (loud_nxt == DET_N) begin
            state <= ATTACK;
`ifdef FBS_CTRL_EVENT_COUNT_EN
            o_event_count <= (o_event_count == 8'hFF) ? o_event_count : o_event_count + 8'd1;
`endif
          end
        end
        ATTACK: begin
          o_gain <= gain_dn_sat;
          if (gain_dn_sat == GAIN_MIN) begin
            state    <= HOLD;
            hold_cnt <= '0;
          end
        end
        HOLD: begin
          o_gain   <= GAIN_MIN;
          hold_cnt <= loud ? 16'd0 : hold_cnt + 16'd1;
          if (!loud && hold_cnt + 16'd1 == HOLD_N) state <= RELEASE;
        end
        default: begin
          if (loud) state <= ATTACK;
          else begin
            o_gain <= gain_up_sat;
            if (gain_up_sat == 8'hFF) begin
              state    <= MONITOR;
              loud_cnt <= '0;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_feedback_suppressor_ctrl.sv
// tb_feedback_suppressor_ctrl: directed and random checks of the gain sequencer against an integer reference model.
module tb_feedback_suppressor_ctrl;
  logic       clk = 0, rst, en, valid;
  logic [7:0] data, gain;
  logic       active;
  logic [1:0] st;
`ifdef FBS_CTRL_EVENT_COUNT_EN
  logic [7:0] ev;
`endif
  int checks = 0, errors = 0;
  int m_state, m_gain, m_loud, m_hold, m_ev;
  feedback_suppressor_ctrl dut (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_valid(valid), .i_data(data),
    .o_gain(gain),
`ifdef FBS_CTRL_EVENT_COUNT_EN
    .o_event_count(ev),
`endif
    .o_active(active), .o_state(st)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic model(input bit r, input bit e, input bit v, input logic [7:0] d);
    int s, mag;
    bit loud;
    s = $signed(d);
    mag = (s < 0) ? -s : s;
    if (mag > 127) mag = 127;
    loud = mag >= 100;
    if (r) begin
      m_state = 0; m_gain = 255; m_loud = 0; m_hold = 0; m_ev = 0;
    end else if (!e) begin
      m_state = 0; m_gain = 255; m_loud = 0; m_hold = 0;
    end else if (v) begin
      case (m_state)
        0: begin
          m_loud = loud ? ((m_loud + 1 > 16) ? 16 : m_loud + 1) : 0;
          if (m_loud == 16) begin
            m_state = 1;
            m_ev = (m_ev + 1 > 255) ? 255 : m_ev + 1;
          end
        end
        1: begin
          m_gain = (m_gain - 16 < 64) ? 64 : m_gain - 16;
          if (m_gain == 64) begin m_state = 2; m_hold = 0; end
        end
        2: if (loud) m_hold = 0;
           else begin m_hold++; if (m_hold == 32) m_state = 3; end
        default: if (loud) m_state = 1;
           else begin
             m_gain = (m_gain + 16 > 255) ? 255 : m_gain + 16;
             if (m_gain == 255) begin m_state = 0; m_loud = 0; end
           end
      endcase
    end
  endtask
  task automatic step(input bit r, input bit e, input bit v, input logic [7:0] d);
    rst = r; en = e; valid = v; data = d;
    @(posedge clk);
    model(r, e, v, d);
    #1;
    check("gain", 16'(gain), 16'(m_gain));
    check("state", 16'(st), 16'(m_state));
    check("active", 16'(active), 16'(m_state != 0));
`ifdef FBS_CTRL_EVENT_COUNT_EN
    check("event_count", 16'(ev), 16'(m_ev));
`endif
  endtask
  initial begin
    int p;
    logic [7:0] d;
    logic [7:0] att [12] = '{8'hEF, 8'hDF, 8'hCF, 8'hBF, 8'hAF, 8'h9F, 8'h8F, 8'h7F, 8'h6F, 8'h5F, 8'h4F, 8'h40};
    rst = 1; en = 1; valid = 0; data = 0;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1'($urandom), 8'($urandom));
      check("reset_gain", 16'(gain), 16'hFF);
      check("reset_state", 16'(st), 16'd0);
    end
    for (int i = 0; i < 15; i++) begin
      step(0, 1, 1, 8'd120);
      step(0, 1, 0, 8'd120);
    end
    check("no_trigger_15", 16'(st), 16'd0);
    step(0, 1, 1, 8'd50);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("pre_trigger", 16'(st), 16'd0);
      step(0, 1, 1, 8'd120);
      if (i % 4 == 0) step(0, 1, 0, 8'd0);
    end
    check("trigger_state", 16'(st), 16'd1);
    check("trigger_active", 16'(active), 16'd1);
    check("trigger_gain", 16'(gain), 16'hFF);
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 1, 8'd120);
      check("attack_gain", 16'(gain), 16'(att[i]));
    end
    check("attack_to_hold", 16'(st), 16'd2);
    for (int i = 0; i < 20; i++) step(0, 1, 1, 8'd10);
    step(0, 1, 1, 8'h80);
    for (int i = 0; i < 32; i++) begin
      if (i == 31) check("hold_before_release", 16'(st), 16'd2);
      step(0, 1, 1, 8'd10);
    end
    check("release_entry", 16'(st), 16'd3);
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 1, 8'd10);
      check("release_gain", 16'(gain), (i == 11) ? 16'hFF : 16'(8'h50 + 8'(i * 16)));
    end
    check("release_done", 16'(st), 16'd0);
    for (int i = 0; i < 16; i++) step(0, 1, 1, 8'h9C);
    for (int i = 0; i < 12; i++) step(0, 1, 1, 8'd127);
    for (int i = 0; i < 32; i++) step(0, 1, 1, 8'hF6);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 8'd0);
    check("release_at_70", 16'(gain), 16'h70);
    step(0, 1, 1, 8'h80);
    check("interrupt_state", 16'(st), 16'd1);
    check("interrupt_gain", 16'(gain), 16'h70);
    step(0, 1, 1, 8'h80);
    check("reattack_gain", 16'(gain), 16'h60);
    step(0, 0, 1, 8'h80);
    check("disable_state", 16'(st), 16'd0);
    check("disable_gain", 16'(gain), 16'hFF);
`ifdef FBS_CTRL_EVENT_COUNT_EN
    check("event_survives", 16'(ev), 16'd2);
`endif
    p = 50;
    for (int i = 0; i < 4000; i++) begin
      if (i % 80 == 0) p = $urandom_range(0, 100);
      if ($urandom_range(0, 99) < p) begin
        d = 8'($urandom_range(100, 128));
        if ($urandom_range(0, 1) == 1) d = -d;
      end else begin
        d = 8'($urandom_range(0, 99));
        if ($urandom_range(0, 1) == 1) d = -d;
      end
      step($urandom_range(0, 799) == 0, $urandom_range(0, 299) != 0, $urandom_range(0, 3) != 0, d);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/feedback_suppressor_ctrl.md
Name: feedback_suppressor_ctrl

Overview:
Gain-sequencing controller for the feedback suppressor audio path. It watches the 8-bit sample stream for a sustained howl, defined as consecutive samples whose magnitude is at or above a threshold. It then sequences a suppression gain down (attack), holds it, and ramps it back up (release). `o_gain` drives the datapath gain stage as a Q0.8 multiplier, where 8'hFF means unity.

Parameters:
- THRESHOLD, 8'd100, magnitude at or above which a sample counts as "loud".
- DETECT_COUNT, 16, consecutive loud samples needed to declare howl (range 1..255).
- HOLD_SAMPLES, 32, consecutive quiet samples in HOLD before release starts (range 1..65535).
- GAIN_MIN, 8'h40, gain floor during suppression.
- GAIN_STEP, 8'h10, gain decrement/increment applied per valid sample during attack and release.

Ports:
- i_clk, input, 1, system clock.
- i_reset, input, 1, synchronous active-high reset.
- i_enable, input, 1, controller enable; low forces bypass.
- i_valid, input, 1, qualifies i_data; one sample per high cycle.
- i_data, input, 8, signed two's-complement audio sample.
- o_gain, output, 8, gain to datapath, registered.
- o_active, output, 1, high whenever state != MONITOR.
- o_state, output, 2, 0=MONITOR, 1=ATTACK, 2=HOLD, 3=RELEASE.

Behaviour:
- Clocking and reset:
  - Single clock domain. Reset is synchronous and active-high.
  - On reset: o_gain=8'hFF, o_state=MONITOR, o_active=0, all counters 0. Reset mid-operation takes effect at the next edge, with no residual state.
- Magnitude:
  - mag = |i_data|, with -128 saturated to 127.
  - loud = (mag >= THRESHOLD), compared as unsigned 8-bit.
- Sample gating:
  - All counters and gain updates advance only on cycles with i_valid=1. Cycles with i_valid=0 change nothing.
  - Latency: an update caused by a valid sample is visible on the outputs the cycle after that sample.
- Enable:
  - i_enable=0 has priority over everything except reset.
  - Next edge: state=MONITOR, o_gain=8'hFF, loud counter=0, hold counter=0.
- MONITOR:
  - o_gain=8'hFF.
  - On a valid loud sample, loud_cnt increments, saturating at DETECT_COUNT. On a valid quiet sample, loud_cnt resets to 0.
  - The valid sample that brings loud_cnt to DETECT_COUNT moves the state to ATTACK. Gain is unchanged on that edge.
- ATTACK:
  - Each valid sample sets gain <= max(gain - GAIN_STEP, GAIN_MIN). No unsigned wrap: compare before subtracting.
  - When the new gain equals GAIN_MIN, move to HOLD with hold_cnt=0.
  - Loud/quiet status is ignored in this state.
- HOLD:
  - Gain is held at GAIN_MIN.
  - Valid loud sample: hold_cnt <= 0 (retrigger).
  - Valid quiet sample: hold_cnt increments. The quiet sample that makes hold_cnt == HOLD_SAMPLES moves the state to RELEASE.
- RELEASE:
  - Valid loud sample: go to ATTACK, gain unchanged on that edge. This takes precedence over the ramp.
  - Valid quiet sample: gain <= min(gain + GAIN_STEP, 8'hFF), saturating with no wrap. When the new gain reaches 8'hFF, go to MONITOR with loud_cnt=0.
- Widths:
  - loud_cnt is 8 bits.
  - hold_cnt is 16 bits.
  - Gain arithmetic uses a 9-bit intermediate for the saturation check.
- o_active is derived from the registered state, with no extra latency.

Optional Feature:
- Macro: FBS_CTRL_EVENT_COUNT_EN.
- When defined:
  - Adds output port o_event_count[7:0].
  - It increments on every MONITOR->ATTACK transition and saturates at 8'hFF.
  - It is cleared only by i_reset; i_enable=0 does not clear it.
- When undefined: the port and its counter are absent, and all other behaviour is identical.

Test Plan:
1. Reset: assert i_reset 3 cycles with random i_data/i_valid -> o_gain=8'hFF, o_state=0, o_active=0 on every cycle after the first reset edge.
2. Detection: 15 valid samples of 120, then 1 of 50, then 16 of 120 -> no trigger after the first 15. State becomes ATTACK (o_active=1) the cycle after the 16th sample of the second run. Interleaved i_valid=0 cycles do not break the count.
3. Attack: continue valid 120 samples -> o_gain sequence EF,DF,CF,BF,AF,9F,8F,7F,6F,5F,4F,40 (clamped). State is HOLD after the 12th sample.
4. Hold/release: in HOLD send 20 quiet samples (value 10), 1 loud sample (-128), then 32 quiet samples -> the loud sample retriggers, and RELEASE is entered after the 32nd quiet sample. Further quiet samples give o_gain 50,60,...,F0,FF, then MONITOR.
5. Release interrupt: in RELEASE at gain 8'h70, send sample -128 -> state ATTACK, gain stays 70. The next loud sample gives 60.
6. Enable override: deassert i_enable mid-ATTACK -> next cycle o_state=MONITOR, o_gain=FF. With FBS_CTRL_EVENT_COUNT_EN, o_event_count equals the number of triggers so far (e.g. 2) and survives the enable drop.
